// File: rtl/pid_axis_scheduler.sv
// pid_axis_scheduler: shares one PID compute core between the yaw, roll and
// pitch axes. Each accepted start snapshots the six rate inputs, runs three
// start/done transactions in the order yaw, roll, pitch, then publishes all
// three corrected rates together with a one-cycle out_valid strobe.
//
// Optional build macro: PID_SCHED_TIMEOUT_EN
//   defined   - a per-axis WAIT timeout forces that axis result to 0 and sets
//               its axis_fault bit after TIMEOUT_CYCLES cycles without done.
//   undefined - WAIT waits for core_done indefinitely, axis_fault reads 0.
//
// state | meaning
// IDLE  | waiting for start; rate outputs hold the last published values
// ISSUE | core_start pulse for the current axis, operands presented
// WAIT  | operands held stable until core_done (or timeout) for this axis
// DONE  | rate outputs freshly loaded, out_valid high for this one cycle

module pid_axis_scheduler #(
    parameter int N_RATE         = 36,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              sys_clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [N_RATE-1:0] yaw_target,
    input  logic [N_RATE-1:0] roll_target,
    input  logic [N_RATE-1:0] pitch_target,
    input  logic [N_RATE-1:0] yaw_actual,
    input  logic [N_RATE-1:0] roll_actual,
    input  logic [N_RATE-1:0] pitch_actual,
    output logic              core_start,
    output logic [1:0]        core_axis,
    output logic [N_RATE-1:0] core_target,
    output logic [N_RATE-1:0] core_actual,
    input  logic              core_done,
    input  logic [N_RATE-1:0] core_result,
    output logic [N_RATE-1:0] yaw_rate_out,
    output logic [N_RATE-1:0] roll_rate_out,
    output logic [N_RATE-1:0] pitch_rate_out,
    output logic              out_valid,
    output logic              busy,
    output logic [7:0]        overrun_cnt,
    output logic [2:0]        axis_fault
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state;
    logic [1:0]        axis;
    logic [1:0]        axis_next;
    logic [N_RATE-1:0] snap_roll_t;
    logic [N_RATE-1:0] snap_roll_a;
    logic [N_RATE-1:0] snap_pitch_t;
    logic [N_RATE-1:0] snap_pitch_a;
    logic [N_RATE-1:0] res_yaw;
    logic [N_RATE-1:0] res_roll;
    logic              timed_out;
    logic              advance;
    logic [N_RATE-1:0] wait_value;

`ifdef PID_SCHED_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt;

    // A real done in the last allowed cycle wins over the timeout.
    assign timed_out = (state == WAIT) && !core_done && (tmo_cnt == TMO_LAST);

    // WAIT cycle counter and sticky per-axis fault flags (cleared per sample).
    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            tmo_cnt    <= '0;
            axis_fault <= '0;
        end else begin
            if (state == IDLE && start)
                axis_fault <= '0;
            else if (timed_out)
                axis_fault[axis] <= 1'b1;

            if (state != WAIT)
                tmo_cnt <= '0;
            else if (!core_done)
                tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    logic [31:0] timeout_unused;

    // Timeout depth only matters in the timeout build.
    assign timeout_unused = TIMEOUT_CYCLES;
    assign timed_out      = 1'b0;
    assign axis_fault     = 3'b000;
`endif

    assign advance    = core_done || timed_out;
    assign wait_value = core_done ? core_result : '0;
    assign axis_next  = axis + 2'd1;

    // Sequencer: snapshot, three core transactions, publish, overrun count.
    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            state          <= IDLE;
            axis           <= 2'd0;
            busy           <= 1'b0;
            core_start     <= 1'b0;
            core_axis      <= 2'd0;
            core_target    <= '0;
            core_actual    <= '0;
            snap_roll_t    <= '0;
            snap_roll_a    <= '0;
            snap_pitch_t   <= '0;
            snap_pitch_a   <= '0;
            res_yaw        <= '0;
            res_roll       <= '0;
            yaw_rate_out   <= '0;
            roll_rate_out  <= '0;
            pitch_rate_out <= '0;
            out_valid      <= 1'b0;
            overrun_cnt    <= 8'd0;
        end else begin
            core_start <= 1'b0;
            out_valid  <= 1'b0;

            if (start && state != IDLE && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;

            case (state)
                IDLE: begin
                    if (start) begin
                        // Yaw goes straight from the inputs, so it needs no snapshot copy.
                        snap_roll_t  <= roll_target;
                        snap_roll_a  <= roll_actual;
                        snap_pitch_t <= pitch_target;
                        snap_pitch_a <= pitch_actual;
                        axis         <= 2'd0;
                        core_start   <= 1'b1;
                        core_axis    <= 2'd0;
                        core_target  <= yaw_target;
                        core_actual  <= yaw_actual;
                        busy         <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (advance) begin
                        case (axis)
                            2'd0:    res_yaw  <= wait_value;
                            2'd1:    res_roll <= wait_value;
                            default: begin
                                yaw_rate_out   <= res_yaw;
                                roll_rate_out  <= res_roll;
                                pitch_rate_out <= wait_value;
                            end
                        endcase
                        if (axis != 2'd2) begin
                            axis        <= axis_next;
                            core_start  <= 1'b1;
                            core_axis   <= axis_next;
                            core_target <= (axis_next == 2'd1) ? snap_roll_t : snap_pitch_t;
                            core_actual <= (axis_next == 2'd1) ? snap_roll_a : snap_pitch_a;
                            state       <= ISSUE;
                        end else begin
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_axis_scheduler.sv
// Scoreboard bench for pid_axis_scheduler. Stimulus pushes expected core
// transactions and expected published results into queues; a core model and
// an output monitor pop and compare independently. The reference is the
// timing rule "out_valid appears 6 + sum(per-axis done delays) edges after
// the accepting edge" plus a stand-in PID function.

module tb_pid_axis_scheduler;

    localparam int N = 36;
`ifdef PID_SCHED_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 256;
`endif
    localparam int DMAX = (TMO - 1 < 12) ? TMO - 1 : 12;

    logic         sys_clk;
    logic         resetn;
    logic         start;
    logic [N-1:0] yaw_target, roll_target, pitch_target;
    logic [N-1:0] yaw_actual, roll_actual, pitch_actual;
    logic         core_start;
    logic [1:0]   core_axis;
    logic [N-1:0] core_target, core_actual;
    logic         core_done;
    logic [N-1:0] core_result;
    logic [N-1:0] yaw_rate_out, roll_rate_out, pitch_rate_out;
    logic         out_valid;
    logic         busy;
    logic [7:0]   overrun_cnt;
    logic [2:0]   axis_fault;

    pid_axis_scheduler #(.N_RATE(N), .TIMEOUT_CYCLES(TMO)) dut (
        .sys_clk(sys_clk), .resetn(resetn), .start(start),
        .yaw_target(yaw_target), .roll_target(roll_target), .pitch_target(pitch_target),
        .yaw_actual(yaw_actual), .roll_actual(roll_actual), .pitch_actual(pitch_actual),
        .core_start(core_start), .core_axis(core_axis),
        .core_target(core_target), .core_actual(core_actual),
        .core_done(core_done), .core_result(core_result),
        .yaw_rate_out(yaw_rate_out), .roll_rate_out(roll_rate_out),
        .pitch_rate_out(pitch_rate_out), .out_valid(out_valid), .busy(busy),
        .overrun_cnt(overrun_cnt), .axis_fault(axis_fault)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]   ax;
        logic [N-1:0] t;
        logic [N-1:0] a;
        int           d;
    } op_t;

    typedef struct {
        logic [N-1:0] r0;
        logic [N-1:0] r1;
        logic [N-1:0] r2;
        logic [2:0]   fault;
        int           edge_no;
    } exp_t;

    op_t  op_q[$];
    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    int busy_until = -1000;
    int busy_end   = -1000;
    int cur_e      = -1000;
    int exp_ovr    = 0;

    logic [N-1:0] nt[3];
    logic [N-1:0] na[3];
    int           nd[3];

    logic [N-1:0] hold_y, hold_r, hold_p;
    bit           hold_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Stand-in for the PID core: any deterministic function of the operands.
    function automatic logic [N-1:0] ref_pid(input logic [N-1:0] t, input logic [N-1:0] a,
                                             input int ax);
        return t - a + N'(ax);
    endfunction

    function automatic logic [N-1:0] rnd_rate();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        return v[N-1:0];
    endfunction

    function automatic int rnd_delay();
`ifdef PID_SCHED_TIMEOUT_EN
        if ($urandom_range(0, 5) == 0) return -1;
`endif
        return $urandom_range(0, DMAX);
    endfunction

    task automatic scramble();
        for (int i = 0; i < 3; i++) begin
            nt[i] = rnd_rate();
            na[i] = rnd_rate();
        end
    endtask

    // One clock of stimulus: decide accept/drop from the model, then check
    // overrun_cnt and busy after the edge.
    task automatic step(input bit do_start);
        int           k;
        int           s;
        int           eff;
        bit           acc;
        op_t          op;
        exp_t         e;
        logic [N-1:0] res[3];
        if (!do_start) scramble();
        yaw_target   = nt[0];
        roll_target  = nt[1];
        pitch_target = nt[2];
        yaw_actual   = na[0];
        roll_actual  = na[1];
        pitch_actual = na[2];
        start        = do_start;
        k   = cyc + 1;
        acc = 1'b0;
        if (do_start) begin
            if (k <= busy_until) begin
                if (exp_ovr < 255) exp_ovr++;
            end else begin
                acc     = 1'b1;
                s       = 0;
                e.fault = 3'b000;
                for (int i = 0; i < 3; i++) begin
                    if (nd[i] > DMAX) nd[i] = DMAX;
                    eff = (nd[i] < 0) ? TMO - 1 : nd[i];
                    s  += eff;
                    res[i] = (nd[i] < 0) ? '0 : ref_pid(nt[i], na[i], i);
                    if (nd[i] < 0) e.fault[i] = 1'b1;
                    op.ax = 2'(i);
                    op.t  = nt[i];
                    op.a  = na[i];
                    op.d  = nd[i];
                    op_q.push_back(op);
                end
                e.r0      = res[0];
                e.r1      = res[1];
                e.r2      = res[2];
                e.edge_no = k + 6 + s;
                exp_q.push_back(e);
                cur_e      = k;
                busy_end   = k + 6 + s;
                busy_until = k + 7 + s;
            end
        end
        @(negedge sys_clk);
        start = 1'b0;
        chk("overrun_cnt", overrun_cnt, exp_ovr);
        chk("busy", busy, (cyc >= cur_e && cyc <= busy_end));
        if (acc) chk("fault_clear_on_start", axis_fault, 0);
    endtask

    task automatic run_to_idle();
        while (cyc + 1 <= busy_until) step(1'b0);
    endtask

    task automatic chk_zero();
        chk("rst_yaw_rate", yaw_rate_out, 0);
        chk("rst_roll_rate", roll_rate_out, 0);
        chk("rst_pitch_rate", pitch_rate_out, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_axis", core_axis, 0);
        chk("rst_core_target", core_target, 0);
        chk("rst_core_actual", core_actual, 0);
        chk("rst_overrun", overrun_cnt, 0);
        chk("rst_axis_fault", axis_fault, 0);
    endtask

    task automatic do_reset();
        hold_en = 1'b0;
        resetn  = 1'b0;
        start   = 1'b0;
        @(negedge sys_clk);
        chk_zero();
        @(negedge sys_clk);
        op_q.delete();
        exp_q.delete();
        busy_until = -1000;
        busy_end   = -1000;
        cur_e      = -1000;
        exp_ovr    = 0;
        hold_y     = '0;
        hold_r     = '0;
        hold_p     = '0;
        resetn     = 1'b1;
        hold_en    = 1'b1;
    endtask

    // Shared PID core model: checks operands against the bench's own
    // expectation for the whole WAIT, answers after the scheduled delay.
    initial begin : core_model
        op_t op;
        int  eff;
        core_done   = 1'b0;
        core_result = '0;
        forever begin
            @(negedge sys_clk);
            core_done = 1'b0;
            if (resetn && core_start) begin
                if (op_q.size() == 0) begin
                    chk("core_start_unexpected", core_start, 0);
                end else begin
                    op = op_q.pop_front();
                    chk("core_axis", core_axis, op.ax);
                    chk("core_target", core_target, op.t);
                    chk("core_actual", core_actual, op.a);
                    eff = (op.d < 0) ? TMO - 1 : op.d;
                    for (int i = 0; i <= eff; i++) begin
                        @(negedge sys_clk);
                        if (!resetn) begin
                            core_done = 1'b0;
                            break;
                        end
                        if (i == 0) chk("core_start_width", core_start, 0);
                        chk("core_axis_hold", core_axis, op.ax);
                        chk("core_target_hold", core_target, op.t);
                        chk("core_actual_hold", core_actual, op.a);
                        if (i == eff && op.d >= 0) begin
                            core_done   = 1'b1;
                            core_result = ref_pid(op.t, op.a, int'(op.ax));
                        end
                    end
                end
            end
        end
    end

    // Output monitor: every out_valid must match the oldest expected result
    // at the predicted edge; between strobes the rate outputs must hold.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (resetn) begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("out_valid_unexpected", out_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("yaw_rate_out", yaw_rate_out, e.r0);
                        chk("roll_rate_out", roll_rate_out, e.r1);
                        chk("pitch_rate_out", pitch_rate_out, e.r2);
                        chk("axis_fault", axis_fault, e.fault);
                        chk("out_valid_cycle", cyc, e.edge_no);
                        hold_y = e.r0;
                        hold_r = e.r1;
                        hold_p = e.r2;
                    end
                end else if (hold_en) begin
                    chk("yaw_hold", yaw_rate_out, hold_y);
                    chk("roll_hold", roll_rate_out, hold_r);
                    chk("pitch_hold", pitch_rate_out, hold_p);
                end
            end
        end
    end

    initial begin : stimulus
        resetn = 1'b0;
        start  = 1'b0;
        yaw_target = '0; roll_target = '0; pitch_target = '0;
        yaw_actual = '0; roll_actual = '0; pitch_actual = '0;
        do_reset();

        // Minimum-latency sequence with known operands.
        nt = '{N'(100), N'(200), N'(300)};
        na = '{N'(1), N'(2), N'(3)};
        nd = '{0, 0, 0};
        step(1'b1);
        run_to_idle();

        // Uneven done delays.
        scramble();
        nd = '{5, 0, 12};
        step(1'b1);
        run_to_idle();

        // Restarts at cycles 3, 4 and in the DONE cycle, then back-to-back.
        scramble();
        nd = '{2, 2, 2};
        step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        while (cyc + 1 < busy_until) step(1'b0);
        step(1'b1);
        scramble();
        nd = '{rnd_delay(), rnd_delay(), rnd_delay()};
        step(1'b1);
        run_to_idle();

`ifdef PID_SCHED_TIMEOUT_EN
        // Pitch never answers, then the next sample clears the flag.
        scramble();
        nd = '{0, 0, -1};
        step(1'b1);
        run_to_idle();
        scramble();
        nd = '{1, TMO - 1, 0};
        step(1'b1);
        run_to_idle();
`endif

        // Start held high for long sequences: overrun saturates at 255.
        nd = '{12, 12, 12};
        for (int c = 0; c < 8 * 44; c++) begin
            scramble();
            step(1'b1);
        end
        run_to_idle();
        chk("overrun_saturated", overrun_cnt, 255);

        // Reset during the roll WAIT abandons the sample.
        scramble();
        nd = '{3, 6, 3};
        step(1'b1);
        while (cyc < cur_e + 7) step(1'b0);
        do_reset();
        scramble();
        nd = '{1, 2, 3};
        step(1'b1);
        run_to_idle();

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            scramble();
            nd = '{rnd_delay(), rnd_delay(), rnd_delay()};
            step($urandom_range(0, 3) == 0);
        end
        run_to_idle();
        repeat (4) step(1'b0);

        chk("results_outstanding", exp_q.size(), 0);
        chk("core_ops_outstanding", op_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
